// File: rtl/riscv_pkg.sv
// Shared integer-core constants and types for the register file and its neighbours.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/rb_scoreboard.sv
// Per-register busy bits for in-flight producers and the decode hazard flag.
// REG_BANK_BYPASS_EN: a register retiring this cycle does not raise a hazard.
module rb_scoreboard import riscv_pkg::*; #(
  parameter int NREGS = riscv_pkg::NREGS,
  parameter int AW    = riscv_pkg::REG_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rs_rd_en,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic          rd_issue_valid,
  input  logic [AW-1:0] rd_issue_addr,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  output logic          stall
);

  logic [NREGS-1:0] busy;
  logic             hz1;
  logic             hz2;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wb_en && wb_addr != '0)
        busy[wb_addr] <= 1'b0;
      // Later assignment wins: a new producer issued against the retiring one stays outstanding.
      if (rd_issue_valid && rd_issue_addr != '0 && !stall)
        busy[rd_issue_addr] <= 1'b1;
    end
  end

  always_comb begin
    hz1 = (rs1_addr != '0) && busy[rs1_addr];
    hz2 = (rs2_addr != '0) && busy[rs2_addr];
`ifdef REG_BANK_BYPASS_EN
    if (wb_en && wb_addr == rs1_addr) hz1 = 1'b0;
    if (wb_en && wb_addr == rs2_addr) hz2 = 1'b0;
`endif
    stall = rs_rd_en && (hz1 || hz2);
  end

endmodule

// File: rtl/reg_bank.sv
// Integer register file: write-back port, two registered read ports, RAW stall.
// REG_BANK_BYPASS_EN: same-cycle write-back data is forwarded to the read ports.
module reg_bank import riscv_pkg::*; #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS,
  parameter int AW    = riscv_pkg::REG_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rs_rd_en,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rd_issue_valid,
  input  logic [AW-1:0]   rd_issue_addr,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            stall
);

  if ((1 << AW) != NREGS) begin : g_bad_params
    $error("reg_bank: 2**AW must equal NREGS");
  end

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] val1;
  logic [XLEN-1:0] val2;

  rb_scoreboard #(.NREGS(NREGS), .AW(AW)) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .rs_rd_en       (rs_rd_en),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rd_issue_valid (rd_issue_valid),
    .rd_issue_addr  (rd_issue_addr),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .stall          (stall)
  );

  // x0 is never written, so it reads back as zero without a special case in storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    val1 = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    val2 = (rs2_addr == '0) ? '0 : regs[rs2_addr];
`ifdef REG_BANK_BYPASS_EN
    if (rs1_addr != '0 && wb_en && wb_addr == rs1_addr) val1 = wb_data;
    if (rs2_addr != '0 && wb_en && wb_addr == rs2_addr) val2 = wb_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_data <= '0;
      rs2_data <= '0;
    end else if (rs_rd_en && !stall) begin
      rs1_data <= val1;
      rs2_data <= val2;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios followed by random traffic
// against an array-based reference model (follows REG_BANK_BYPASS_EN when defined).
module tb_reg_bank;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            rs_rd_en;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            rd_issue_valid;
  logic [AW-1:0]   rd_issue_addr;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            stall;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [XLEN-1:0] m_reg [NREGS];
  bit              m_busy [NREGS];
  logic [XLEN-1:0] m_out1;
  logic [XLEN-1:0] m_out2;

  reg_bank dut (
    .clk            (clk),
    .rst            (rst),
    .rs_rd_en       (rs_rd_en),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rd_issue_valid (rd_issue_valid),
    .rd_issue_addr  (rd_issue_addr),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .stall          (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit hazard(input int a);
    if (a == 0 || !m_busy[a]) return 1'b0;
    if (BYP && wb_en && int'(wb_addr) == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [XLEN-1:0] read_val(input int a);
    if (a == 0) return '0;
    if (BYP && wb_en && int'(wb_addr) == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic bit model_stall();
    return rs_rd_en && (hazard(int'(rs1_addr)) || hazard(int'(rs2_addr)));
  endfunction

  // One clock: check the combinational stall, advance the model, check the read ports.
  task automatic tick(input string tag);
    bit              s;
    logic [XLEN-1:0] n1, n2;
    #1;
    s = model_stall();
    check({tag, ".stall"}, {31'd0, stall}, {31'd0, s});
    n1 = m_out1;
    n2 = m_out2;
    if (rs_rd_en && !s) begin
      n1 = read_val(int'(rs1_addr));
      n2 = read_val(int'(rs2_addr));
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_out1 = '0;
      m_out2 = '0;
    end else begin
      if (wb_en && wb_addr != 0) begin
        m_reg[wb_addr]  = wb_data;
        m_busy[wb_addr] = 1'b0;
      end
      if (rd_issue_valid && rd_issue_addr != 0 && !s) m_busy[rd_issue_addr] = 1'b1;
      m_out1 = n1;
      m_out2 = n2;
    end
    #1;
    check({tag, ".rs1"}, rs1_data, m_out1);
    check({tag, ".rs2"}, rs2_data, m_out2);
  endtask

  task automatic drive(input string tag, input bit r, input bit rd, input int a1, input int a2,
                       input bit iv, input int ia, input bit we, input int wa,
                       input logic [XLEN-1:0] wd);
    rst = r; rs_rd_en = rd; rs1_addr = AW'(a1); rs2_addr = AW'(a2);
    rd_issue_valid = iv; rd_issue_addr = AW'(ia);
    wb_en = we; wb_addr = AW'(wa); wb_data = wd;
    tick(tag);
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_out1 = '0;
    m_out2 = '0;
    rst = 1'b1; rs_rd_en = 1'b0; rs1_addr = '0; rs2_addr = '0;
    rd_issue_valid = 1'b0; rd_issue_addr = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    @(negedge clk);

    // reset dominates a write to x5
    drive("rst_wr",  1, 0, 0, 0, 0, 0, 1, 5, 32'hA5A5_A5A5);
    drive("rd_x5",   0, 1, 5, 5, 0, 0, 0, 0, 0);
    check("x5_after_rst", rs1_data, 32'h0);

    // write then read
    drive("wr_x3",   0, 0, 0, 0, 0, 0, 1, 3, 32'hDEAD_BEEF);
    drive("rd_x3",   0, 1, 3, 0, 0, 0, 0, 0, 0);
    check("x3_value", rs1_data, 32'hDEAD_BEEF);

    // x0 discards writes, issue to x0 never stalls
    drive("wr_x0",   0, 0, 0, 0, 1, 0, 1, 0, 32'hFFFF_FFFF);
    drive("rd_x0",   0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("x0_rs1", rs1_data, 32'h0);
    check("x0_rs2", rs2_data, 32'h0);

    // RAW on x7 resolved by write-back
    drive("iss_x7",  0, 0, 0, 0, 1, 7, 0, 0, 0);
    drive("raw_x7",  0, 1, 0, 7, 0, 0, 0, 0, 0);
    check("raw_x7_stall", {31'd0, stall}, 32'd1);
    drive("wb_x7",   0, 1, 0, 7, 0, 0, 1, 7, 32'h1234_5678);
    drive("post_x7", 0, 1, 0, 7, 0, 0, 0, 0, 0);
    check("x7_value", rs2_data, 32'h1234_5678);

    // set and clear collide on x9: set wins
    drive("wr_x9",   0, 0, 0, 0, 0, 0, 1, 9, 32'h0000_0099);
    drive("coll_x9", 0, 0, 0, 0, 1, 9, 1, 9, 32'h0000_0999);
    drive("rd_x9",   0, 1, 9, 9, 0, 0, 0, 0, 0);
    check("x9_busy_stall", {31'd0, stall}, 32'd1);
    drive("wb_x9",   0, 1, 9, 9, 0, 0, 1, 9, 32'h0000_9999);
    drive("post_x9", 0, 1, 9, 9, 0, 0, 0, 0, 0);
    check("x9_value", rs1_data, 32'h0000_9999);

    // reset in the middle of an outstanding RAW on x4
    drive("iss_x4",  0, 0, 0, 0, 1, 4, 0, 0, 0);
    drive("rd_x4",   0, 1, 4, 3, 0, 0, 0, 0, 0);
    drive("rst_mid", 1, 1, 4, 3, 0, 0, 0, 0, 0);
    drive("rd_x4b",  0, 1, 4, 3, 0, 0, 0, 0, 0);
    check("x4_no_stall", {31'd0, stall}, 32'd0);
    check("x3_cleared", rs2_data, 32'h0);

    // random traffic over a narrow register window to provoke hazards
    for (int c = 0; c < 600; c++) begin
      int ia, wa, pick;
      rst      = ($urandom_range(0, 99) == 0);
      rs_rd_en = $urandom_range(0, 3) != 0;
      rs1_addr = AW'($urandom_range(0, 7));
      rs2_addr = AW'($urandom_range(0, 7));
      ia = $urandom_range(0, 7);
      rd_issue_valid = ($urandom_range(0, 2) == 0) && !m_busy[ia];
      rd_issue_addr  = AW'(ia);
      wa = $urandom_range(0, NREGS - 1);
      pick = $urandom_range(0, 7);
      if (m_busy[pick] && $urandom_range(0, 1) == 1) wa = pick;
      wb_en   = $urandom_range(0, 1) == 1;
      wb_addr = AW'(wa);
      wb_data = XLEN'($urandom);
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Integer register file at the far end of the write-back interface.
- Accepts the selected write-back word (memory data or ULA result) plus the register-write control.
- Serves two registered read ports to the decode stage.
- Keeps a per-register busy scoreboard that stalls decode on read-after-write hazards until write-back retires the producer.

Parameters:
- XLEN, 32, data width of each register and of all data ports.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.
- AW, 5, register address width; must satisfy 2**AW == NREGS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- rs_rd_en  input  1  decode requests operand read this cycle.
- rs1_addr  input  AW  source register 1 index.
- rs2_addr  input  AW  source register 2 index.
- rd_issue_valid  input  1  decode issues an instruction that will write rd_issue_addr.
- rd_issue_addr  input  AW  destination of the issuing instruction.
- wb_en  input  1  register-write control from the write-back stage.
- wb_addr  input  AW  write-back destination index.
- wb_data  input  XLEN  write-back word (already mux-selected between memory data and ULA result).
- rs1_data  output  XLEN  registered operand 1.
- rs2_data  output  XLEN  registered operand 2.
- stall  output  1  combinational hazard flag to decode.

Behaviour:
- Reset (rst=1 at a clk edge): all registers cleared to 0; all busy bits cleared; rs1_data/rs2_data = 0. Reset dominates every other input that cycle.
- Write: at clk edge, if wb_en and wb_addr != 0, reg[wb_addr] <= wb_data. Writes to x0 are discarded.
- Read: 1-cycle latency. At clk edge with rs_rd_en=1 and stall=0, rsN_data <= value(rsN_addr). With rs_rd_en=0 or stall=1, rsN_data holds.
  - value(0) = 0 always.
  - value(a), a != 0: wb_data if bypass condition (see Optional Feature), else reg[a].
- Scoreboard: busy[NREGS-1:0], busy[0] is constant 0.
  - Set: rd_issue_valid and rd_issue_addr != 0 and stall=0 -> busy[rd_issue_addr] <= 1.
  - Clear: wb_en and wb_addr != 0 -> busy[wb_addr] <= 0.
  - Set and clear on the same register in the same cycle: set wins (new producer outstanding).
  - Issue while stall=1: ignored (no busy update).
  - wb_en to a non-busy register: legal; register written, busy stays 0.
- Stall (combinational): stall = rs_rd_en and (hz(rs1_addr) or hz(rs2_addr)).
  - hz(0) = 0.
  - hz(a) = busy[a] and not clr_now(a), where clr_now(a) = wb_en and wb_addr == a (bypass build only).
- rs1_addr == rs2_addr is legal; both ports return the same value.
- Single producer per register in flight: decode must not issue a second writer to a busy rd. This is not checked; busy remains a single bit.

Optional Feature:
- Macro REG_BANK_BYPASS_EN.
- Defined:
  - Write-to-read bypass active: a read of register a in the same cycle as wb_en with wb_addr == a (a != 0) returns wb_data.
  - The retiring register does not stall (clr_now term included).
- Undefined:
  - Reads return reg[a] before the write.
  - hz(a) = busy[a]; a retiring register still stalls for that cycle.
  - Adds one cycle of RAW penalty; no wb_data-to-output path.

Decomposition:
- Shared package riscv_pkg: XLEN, NREGS, REG_AW constants; typedefs word_t (logic [XLEN-1:0]) and reg_addr_t (logic [REG_AW-1:0]).
- One sub-module rb_scoreboard: owns busy bits, set/clear priority and hz/stall generation.
- reg_bank holds the storage array, the read muxes/bypass, and the output registers.

Test Plan:
- Reset: drive wb_en=1 to x5 during rst=1, then read x5 -> rs1_data=0, stall=0.
- Write-then-read: wb_en, wb_addr=3, wb_data=0xDEADBEEF; next cycle read rs1=3 -> rs1_data=0xDEADBEEF one cycle later.
- x0: wb_en, wb_addr=0, wb_data=0xFFFFFFFF; read rs1=0, rs2=0 -> both outputs 0; issue to x0 never stalls.
- RAW stall: issue rd=7; next cycle rs_rd_en, rs2_addr=7 -> stall=1, outputs hold.
  - Write-back of x7=0x12345678 with bypass -> stall=0 that cycle, rs2_data=0x12345678 next cycle.
  - Without bypass -> stall=1 that cycle, rs2_data=0x12345678 one cycle later.
- Set/clear collision: same cycle issue rd=9 and wb_en, wb_addr=9 -> busy[9]=1 afterwards; read of 9 stalls until next wb to 9.
- Mid-operation reset: rd=4 busy, stall=1 on read of 4; assert rst one cycle -> stall=0, rs*_data=0, busy all clear.
